// File: rtl/irq_pkg.sv
// Shared definitions for the external-interrupt controller.
// Holds the FSM state encoding and the byte offsets of the register
// window relative to BASE (all registers are 8-byte aligned).
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam logic [5:0] OFF_MASK  = 6'd0;
    localparam logic [5:0] OFF_MODE  = 6'd8;
    localparam logic [5:0] OFF_PEND  = 6'd16;
    localparam logic [5:0] OFF_CAUSE = 6'd24;
    localparam logic [5:0] OFF_EOI   = 6'd32;

endpackage

// File: rtl/irq_controller_if.sv
// Core data-memory bus as seen by the interrupt controller.
// master : the core (drives address, store data and store strobe).
// slave  : the controller (returns combinational read data).
interface irq_controller_if #(
    parameter int N = 64
);
    logic [N-1:0] DM_addr;
    logic [N-1:0] DM_writeData;
    logic         DM_writeEnable;
    logic [N-1:0] DM_readData;

    modport master (
        output DM_addr,
        output DM_writeData,
        output DM_writeEnable,
        input  DM_readData
    );

    modport slave (
        input  DM_addr,
        input  DM_writeData,
        input  DM_writeEnable,
        output DM_readData
    );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set bit of req wins.
// Ports:
//   req  in  NCH  request vector
//   any  out 1    at least one request present
//   id   out IDW  index of the lowest set bit (0 when none)
module irq_prio_enc #(
    parameter int NCH = 8,
    parameter int IDW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    output logic           any,
    output logic [IDW-1:0] id
);

    // Scan from the top down so the lowest index overwrites last and wins.
    always_comb begin
        any = 1'b0;
        id  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            id  = req[i] ? IDW'(i) : id;
            any = any | req[i];
        end
    end

endmodule

// File: rtl/irq_controller.sv
// External-interrupt controller for the single-cycle ARM core.
// NCH sources, each with a mask bit and an edge/level mode bit, are
// arbitrated by fixed priority (lowest index first) and presented to the
// core through the ExtIRQ/ExtIAck handshake. Software services a request
// and then writes EOI to allow the next one.
// Ports:
//   CLOCK_50  in   sole clock, rising edge
//   reset     in   synchronous active-high reset
//   irq_src   in   NCH interrupt sources (synchronous)
//   bus       slave  data-memory bus (register window at BASE)
//   ExtIAck   in   core acknowledge of the exception
//   ExtIRQ    out  registered interrupt request
//   irq_id    out  registered id of the requested / in-service channel
module irq_controller
    import irq_pkg::*;
#(
    parameter int           N    = 64,
    parameter int           NCH  = 8,
    parameter logic [N-1:0] BASE = N'(64'h400),
    parameter int           IDW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [NCH-1:0]    irq_src,
    irq_controller_if.slave   bus,
    input  logic              ExtIAck,
    output logic              ExtIRQ,
    output logic [IDW-1:0]    irq_id
);

    logic [NCH-1:0] mask_r;
    logic [NCH-1:0] mode_r;
    logic [NCH-1:0] pend_r;
    logic [NCH-1:0] src_q_r;
    irq_state_t     state_r;
    logic           ext_irq_r;
    logic [IDW-1:0] irq_id_r;

    logic           sel_mask_s;
    logic           sel_mode_s;
    logic           sel_pend_s;
    logic           sel_cause_s;
    logic           sel_eoi_s;
    logic           eoi_s;
    logic           ack_s;
    logic [NCH-1:0] edge_set_s;
    logic [NCH-1:0] w1c_s;
    logic [NCH-1:0] ack_clr_s;
    logic [NCH-1:0] pend_nxt_s;
    logic [NCH-1:0] eligible_s;
    logic           win_any_s;
    logic [IDW-1:0] win_id_s;
    logic [N-1:0]   rd_s;
    logic           unused_s;

    assign sel_mask_s  = (bus.DM_addr == BASE + N'(OFF_MASK));
    assign sel_mode_s  = (bus.DM_addr == BASE + N'(OFF_MODE));
    assign sel_pend_s  = (bus.DM_addr == BASE + N'(OFF_PEND));
    assign sel_cause_s = (bus.DM_addr == BASE + N'(OFF_CAUSE));
    assign sel_eoi_s   = (bus.DM_addr == BASE + N'(OFF_EOI));

    // Only the low NCH data bits are stored; the rest of the word is ignored.
    assign unused_s = ^bus.DM_writeData;

    assign eoi_s = bus.DM_writeEnable & sel_eoi_s & (state_r == SERVICE);
    assign ack_s = ExtIAck & (state_r == REQ);

    assign edge_set_s = irq_src & ~src_q_r;
    assign w1c_s      = (bus.DM_writeEnable & sel_pend_s) ? bus.DM_writeData[NCH-1:0] : '0;
    assign ack_clr_s  = ack_s ? (NCH'(1'b1) << irq_id_r) : '0;

    // Edge bits: a new edge beats any clear in the same cycle.
    // Level bits simply follow the registered source.
    assign pend_nxt_s = (mode_r & (edge_set_s | (pend_r & ~(w1c_s | ack_clr_s))))
                      | (~mode_r & irq_src);

    assign eligible_s = pend_r & mask_r;

    irq_prio_enc #(
        .NCH (NCH),
        .IDW (IDW)
    ) u_prio (
        .req (eligible_s),
        .any (win_any_s),
        .id  (win_id_s)
    );

    // Configuration, pending and source-history registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            mask_r  <= '0;
            mode_r  <= '0;
            pend_r  <= '0;
            src_q_r <= '0;
        end else begin
            src_q_r <= irq_src;
            pend_r  <= pend_nxt_s;
            if (bus.DM_writeEnable && sel_mask_s) begin
                mask_r <= bus.DM_writeData[NCH-1:0];
            end
            if (bus.DM_writeEnable && sel_mode_s) begin
                mode_r <= bus.DM_writeData[NCH-1:0];
            end
        end
    end

    // Request/acknowledge/EOI handshake with registered ExtIRQ and irq_id.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r   <= IDLE;
            ext_irq_r <= 1'b0;
            irq_id_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_any_s) begin
                        irq_id_r  <= win_id_s;
                        ext_irq_r <= 1'b1;
                        state_r   <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        ext_irq_r <= 1'b0;
                        state_r   <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eoi_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    ext_irq_r <= 1'b0;
                end
            endcase
        end
    end

    // Zero-latency register read mux; anything outside the window reads 0.
    always_comb begin
        rd_s = '0;
        if (sel_mask_s) begin
            rd_s[NCH-1:0] = mask_r;
        end else if (sel_mode_s) begin
            rd_s[NCH-1:0] = mode_r;
        end else if (sel_pend_s) begin
            rd_s[NCH-1:0] = pend_r;
        end else if (sel_cause_s) begin
            rd_s[N-1]     = (state_r == SERVICE);
            rd_s[IDW-1:0] = irq_id_r;
        end else begin
            rd_s = '0;
        end
    end

    assign bus.DM_readData = rd_s;
    assign ExtIRQ          = ext_irq_r;
    assign irq_id          = irq_id_r;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: hand-computed expectations for reset,
// edge/level arbitration, masking, W1C races, resets mid-handshake and
// ignored ack/EOI cases.
module tb_irq_controller;
    import irq_pkg::*;

    localparam int          N    = 64;
    localparam int          NCH  = 8;
    localparam logic [63:0] BASE = 64'h400;
    localparam int          IDW  = 3;
    localparam logic [63:0] SVC  = 64'h8000_0000_0000_0000;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] irq_src;
    logic           ext_iack;
    logic           ext_irq;
    logic [IDW-1:0] irq_id;

    int n_vec = 0;
    int n_err = 0;

    irq_controller_if #(.N(N)) bus ();

    irq_controller #(
        .N    (N),
        .NCH  (NCH),
        .BASE (BASE),
        .IDW  (IDW)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .irq_src  (irq_src),
        .bus      (bus),
        .ExtIAck  (ext_iack),
        .ExtIRQ   (ext_irq),
        .irq_id   (irq_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] off, input logic [63:0] data);
        bus.DM_addr        = BASE + 64'(off);
        bus.DM_writeData   = data;
        bus.DM_writeEnable = 1'b1;
        tick();
        bus.DM_writeEnable = 1'b0;
        bus.DM_writeData   = 64'd0;
    endtask

    task automatic rd(input string tag, input logic [5:0] off, input logic [63:0] exp);
        bus.DM_addr = BASE + 64'(off);
        #1;
        check(tag, bus.DM_readData, exp);
    endtask

    task automatic ack();
        ext_iack = 1'b1;
        tick();
        ext_iack = 1'b0;
    endtask

    task automatic out_chk(input string tag, input logic exp_irq, input logic [IDW-1:0] exp_id);
        check({tag, "_irq"}, 64'(ext_irq), 64'(exp_irq));
        check({tag, "_id"},  64'(irq_id),  64'(exp_id));
    endtask

    initial begin
        reset              = 1'b1;
        irq_src            = 8'h00;
        ext_iack           = 1'b0;
        bus.DM_addr        = 64'd0;
        bus.DM_writeData   = 64'd0;
        bus.DM_writeEnable = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        out_chk("rst", 1'b0, 3'd0);
        rd("rst_mask",  OFF_MASK,  64'd0);
        rd("rst_mode",  OFF_MODE,  64'd0);
        rd("rst_pend",  OFF_PEND,  64'd0);
        rd("rst_cause", OFF_CAUSE, 64'd0);
        rd("rst_eoi",   OFF_EOI,   64'd0);

        // Single edge pulse on channel 3
        wr(OFF_MASK, 64'hFF);
        wr(OFF_MODE, 64'hFF);
        rd("mask_rb", OFF_MASK, 64'hFF);
        irq_src = 8'h08;
        tick();
        irq_src = 8'h00;
        rd("p3_pend", OFF_PEND, 64'h08);
        check("p3_early", 64'(ext_irq), 64'd0);
        tick();
        out_chk("p3_req", 1'b1, 3'd3);
        rd("p3_cause_req", OFF_CAUSE, 64'd3);
        ack();
        check("p3_ack_irq", 64'(ext_irq), 64'd0);
        rd("p3_ack_pend", OFF_PEND, 64'd0);
        rd("p3_cause_svc", OFF_CAUSE, SVC | 64'd3);
        wr(OFF_EOI, 64'h1234);
        rd("p3_cause_idle", OFF_CAUSE, 64'd3);

        // Channels 5 and 2 together: 2 first, then 5
        irq_src = 8'h24;
        tick();
        irq_src = 8'h00;
        tick();
        out_chk("p25_first", 1'b1, 3'd2);
        ack();
        rd("p25_pend", OFF_PEND, 64'h20);
        check("p25_ack_irq", 64'(ext_irq), 64'd0);
        wr(OFF_EOI, 64'd0);
        check("p25_eoi_irq", 64'(ext_irq), 64'd0);
        tick();
        out_chk("p25_second", 1'b1, 3'd5);
        ack();
        wr(OFF_EOI, 64'd0);
        rd("p25_pend_end", OFF_PEND, 64'd0);

        // Level channel 1
        wr(OFF_MODE, 64'hFD);
        irq_src = 8'h02;
        tick();
        tick();
        out_chk("lvl_req", 1'b1, 3'd1);
        ack();
        rd("lvl_pend_ack", OFF_PEND, 64'h02);
        wr(OFF_EOI, 64'd0);
        tick();
        out_chk("lvl_rereq", 1'b1, 3'd1);
        ack();
        irq_src = 8'h00;
        tick();
        wr(OFF_EOI, 64'd0);
        tick();
        tick();
        check("lvl_quiet_irq", 64'(ext_irq), 64'd0);
        rd("lvl_quiet_pend", OFF_PEND, 64'd0);
        rd("lvl_quiet_cause", OFF_CAUSE, 64'd1);

        // Masking and W1C race on channel 0
        wr(OFF_MODE, 64'hFF);
        wr(OFF_MASK, 64'h00);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        tick();
        tick();
        check("msk_irq", 64'(ext_irq), 64'd0);
        rd("msk_pend", OFF_PEND, 64'h01);
        wr(OFF_MASK, 64'h01);
        check("msk_wr_irq", 64'(ext_irq), 64'd0);
        tick();
        out_chk("msk_req", 1'b1, 3'd0);
        irq_src = 8'h01;
        wr(OFF_PEND, 64'h01);
        rd("race_pend", OFF_PEND, 64'h01);
        irq_src = 8'h00;
        wr(OFF_PEND, 64'h01);
        rd("w1c_pend", OFF_PEND, 64'h00);
        check("w1c_hold_irq", 64'(ext_irq), 64'd1);
        ack();
        wr(OFF_EOI, 64'd0);

        // Reset while in REQ
        wr(OFF_MASK, 64'hFF);
        irq_src = 8'h10;
        tick();
        irq_src = 8'h00;
        tick();
        out_chk("rreq_pre", 1'b1, 3'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_chk("rreq", 1'b0, 3'd0);
        rd("rreq_cause", OFF_CAUSE, 64'd0);
        rd("rreq_mask",  OFF_MASK,  64'd0);
        rd("rreq_mode",  OFF_MODE,  64'd0);
        rd("rreq_pend",  OFF_PEND,  64'd0);

        // Reset while in SERVICE
        wr(OFF_MASK, 64'hFF);
        wr(OFF_MODE, 64'hFF);
        irq_src = 8'h40;
        tick();
        irq_src = 8'h00;
        tick();
        ack();
        rd("rsvc_pre", OFF_CAUSE, SVC | 64'd6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_chk("rsvc", 1'b0, 3'd0);
        rd("rsvc_cause", OFF_CAUSE, 64'd0);
        rd("rsvc_mask",  OFF_MASK,  64'd0);
        rd("rsvc_mode",  OFF_MODE,  64'd0);

        // Ack in IDLE and EOI in REQ are ignored
        wr(OFF_MODE, 64'hFF);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        ack();
        rd("idle_ack_pend",  OFF_PEND,  64'h01);
        rd("idle_ack_cause", OFF_CAUSE, 64'd0);
        check("idle_ack_irq", 64'(ext_irq), 64'd0);
        wr(OFF_MASK, 64'h01);
        tick();
        out_chk("eoi_req_pre", 1'b1, 3'd0);
        wr(OFF_EOI, 64'd0);
        out_chk("eoi_req", 1'b1, 3'd0);
        rd("eoi_req_cause", OFF_CAUSE, 64'd0);
        rd("eoi_req_pend",  OFF_PEND,  64'h01);
        ack();
        rd("eoi_svc_cause", OFF_CAUSE, SVC);
        wr(OFF_EOI, 64'd0);
        rd("eoi_idle_cause", OFF_CAUSE, 64'd0);

        // Outside the window reads 0
        bus.DM_addr = BASE + 64'd40;
        #1;
        check("oob_read", bus.DM_readData, 64'd0);
        wr(OFF_MASK, 64'hA5);
        bus.DM_addr = BASE - 64'd8;
        #1;
        check("below_read", bus.DM_readData, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
